// File: rtl/memory_request_arbiter_if.sv
// ----------------------------------------------------------------------------
// memory_request_arbiter_if
//   Bundles the requester-side and memory-manager-side signals of the pixel
//   port arbiter.
//   Modports:
//     slave  : the arbiter itself (samples requests and completions, drives
//              grants, done strobes, read data and the manager request lines)
//     master : the environment (requesters plus framebuffer memory manager)
//   Requester i occupies req_x[9i+8:9i], req_y[8i+7:8i], req_wdata[8i+7:8i].
// ----------------------------------------------------------------------------
interface memory_request_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int IDW     = 3
);
  // requester side
  logic [NUM_REQ-1:0]   req_read;
  logic [NUM_REQ-1:0]   req_write;
  logic [NUM_REQ*9-1:0] req_x;
  logic [NUM_REQ*8-1:0] req_y;
  logic [NUM_REQ*8-1:0] req_wdata;
  logic [NUM_REQ-1:0]   req_done;
  logic [7:0]           rdata;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  // memory manager side
  logic [8:0]           mem_x;
  logic [7:0]           mem_y;
  logic                 mem_read_request;
  logic                 mem_write_request;
  logic [7:0]           mem_write_data;
  logic [7:0]           mem_read_data;
  logic                 mem_read_complete;
  logic                 mem_write_complete;

  modport slave (
    input  req_read, req_write, req_x, req_y, req_wdata,
    input  mem_read_data, mem_read_complete, mem_write_complete,
    output req_done, rdata, grant_id, busy,
    output mem_x, mem_y, mem_read_request, mem_write_request, mem_write_data
  );

  modport master (
    output req_read, req_write, req_x, req_y, req_wdata,
    output mem_read_data, mem_read_complete, mem_write_complete,
    input  req_done, rdata, grant_id, busy,
    input  mem_x, mem_y, mem_read_request, mem_write_request, mem_write_data
  );
endinterface

// File: rtl/memory_request_arbiter.sv
// ----------------------------------------------------------------------------
// memory_request_arbiter
//   Shares the single pixel read/write port of the framebuffer memory manager
//   among NUM_REQ requesters. Round-robin choice, one downstream transaction
//   at a time, one-cycle req_done strobe (plus rdata for reads) on completion.
//   Ports:
//     clock : system clock, posedge
//     reset : synchronous, active-high
//     bus   : memory_request_arbiter_if.slave (requests, grants, manager port)
//   Optional build macro:
//     ARB_PRIORITY0_EN : requester 0 gets strict priority; the rest rotate
//                        among 1..NUM_REQ-1 and requester-0 grants leave the
//                        rotation pointer untouched.
// ----------------------------------------------------------------------------
module memory_request_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDW     = 3
) (
  input logic                     clock,
  input logic                     reset,
  memory_request_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [8:0]         mem_x_q, mem_x_d;
  logic [7:0]         mem_y_q, mem_y_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               rd_req_q, rd_req_d;
  logic               wr_req_q, wr_req_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [7:0]         rdata_q, rdata_d;

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] rr_pending;
  logic               pick_valid;
  logic [IDW-1:0]     pick;

  assign pending = bus.req_read | bus.req_write;

`ifdef ARB_PRIORITY0_EN
  // Requester 0 is served by the priority override, not by the rotation.
  assign rr_pending = pending & {{(NUM_REQ-1){1'b1}}, 1'b0};
`else
  assign rr_pending = pending;
`endif

  // First pending requester at or above the pointer, wrapping around.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    idx        = 0;
    pick_valid = 1'b0;
    pick       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_valid && rr_pending[idx]) begin
        pick_valid = 1'b1;
        pick       = IDW'(idx);
      end
    end
`ifdef ARB_PRIORITY0_EN
    if (pending[0]) begin
      pick_valid = 1'b1;
      pick       = '0;
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    int p;
    p        = int'(pick);
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    mem_x_d  = mem_x_q;
    mem_y_d  = mem_y_q;
    wdata_d  = wdata_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    busy_d   = busy_q;
    rdata_d  = rdata_q;
    done_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d  = pick;
          mem_x_d  = bus.req_x[9*p +: 9];
          mem_y_d  = bus.req_y[8*p +: 8];
          wdata_d  = bus.req_wdata[8*p +: 8];
          // A write takes precedence over a simultaneous read.
          wr_req_d = bus.req_write[p];
          rd_req_d = ~bus.req_write[p];
          busy_d   = 1'b1;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        // Exactly one of rd_req_q/wr_req_q is high here; a completion of the
        // other type is not ours and is ignored.
        if ((wr_req_q && bus.mem_write_complete) ||
            (rd_req_q && bus.mem_read_complete)) begin
          if (rd_req_q) rdata_d = bus.mem_read_data;
          rd_req_d         = 1'b0;
          wr_req_d         = 1'b0;
          done_d[grant_q]  = 1'b1;
`ifdef ARB_PRIORITY0_EN
          if (grant_q != '0)
`endif
          begin
            if (grant_q == IDW'(NUM_REQ-1)) ptr_d = '0;
            else                            ptr_d = grant_q + 1'b1;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      mem_x_q  <= '0;
      mem_y_q  <= '0;
      wdata_q  <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      mem_x_q  <= mem_x_d;
      mem_y_q  <= mem_y_d;
      wdata_q  <= wdata_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.req_done          = done_q;
  assign bus.rdata             = rdata_q;
  assign bus.grant_id          = grant_q;
  assign bus.busy              = busy_q;
  assign bus.mem_x             = mem_x_q;
  assign bus.mem_y             = mem_y_q;
  assign bus.mem_read_request  = rd_req_q;
  assign bus.mem_write_request = wr_req_q;
  assign bus.mem_write_data    = wdata_q;

endmodule

// File: doc/memory_request_arbiter.md
Name: memory_request_arbiter

Overview:
- Shares the single pixel read/write port of the framebuffer memory manager among NUM_REQ requesters, e.g. host bus interface, fill/blit engine and palette/readback unit.
- Uses round-robin arbitration and issues one transaction at a time downstream.
- Waits for the manager's completion pulse, then returns a one-cycle done strobe and, for reads, the data to the granted requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- IDW, 3, width of grant index; must satisfy 2**IDW >= NUM_REQ

Ports:
- clock  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high
- req_read  input  NUM_REQ  per-requester read request; level, held until req_done
- req_write  input  NUM_REQ  per-requester write request; level, held until req_done
- req_x  input  NUM_REQ*9  packed X coords; requester i at [9i+8:9i]
- req_y  input  NUM_REQ*8  packed Y coords; requester i at [8i+7:8i]
- req_wdata  input  NUM_REQ*8  packed write data; requester i at [8i+7:8i]
- req_done  output  NUM_REQ  one-cycle completion strobe to granted requester
- rdata  output  8  read data; valid while req_done high, held until next read completes
- grant_id  output  IDW  index of current/last granted requester
- busy  output  1  high from grant until DONE exits
- mem_x  output  9  to manager memoryXCoord
- mem_y  output  8  to manager memoryYCoord
- mem_read_request  output  1  to manager memoryReadRequest
- mem_write_request  output  1  to manager memoryWriteRequest
- mem_write_data  output  8  to manager memoryWriteData
- mem_read_data  input  8  from manager memoryReadData
- mem_read_complete  input  1  from manager memoryReadComplete (1-cycle pulse)
- mem_write_complete  input  1  from manager memoryWriteComplete (1-cycle pulse)

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; round-robin pointer 0.
  - Reset mid-transaction abandons it with no req_done.
- Pending[i] = req_read[i] | req_write[i].
- If both are high for one requester, write wins and the read is ignored for that grant.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If any pending, pick the first pending index scanning upward from the pointer, wrapping modulo NUM_REQ.
  - Register grant_id, mem_x/mem_y/mem_write_data from that requester's slice, and the op type.
  - Assert mem_write_request or mem_read_request and busy. Go to ISSUE.
  - Outputs take effect the cycle after the request is seen (1-cycle grant latency).
- ISSUE:
  - Hold the mem_* outputs stable; ignore changes on the requester's inputs, which are already captured.
  - On mem_write_complete (write op) or mem_read_complete (read op): deassert the mem request.
  - For a read, capture mem_read_data into rdata.
  - Set req_done[grant_id]=1. Pointer = grant_id+1 mod NUM_REQ. Go to DONE.
  - A complete pulse of the wrong type is ignored.
- DONE:
  - Single cycle; req_done is high exactly this cycle. busy remains 1. Next state IDLE.
  - Requesters drop their request on the edge leaving DONE, so IDLE never re-grants a finished request.
- A requester dropping its request during ISSUE does not abort the transaction; done still pulses.
- Minimum turnaround is IDLE+ISSUE+DONE, with the manager's 6-phase schedule dominating.
- There is never more than one outstanding downstream request.
- The mem request is deasserted before the manager's next VIDEO_READ decision phase.
- Requests arriving while busy wait; no loss and no queueing beyond the request levels.
- Fairness: with all requesters continuously pending, grants rotate 0,1,2,0,... and no requester waits more than NUM_REQ-1 transactions.

Optional Feature:
- Macro: ARB_PRIORITY0_EN.
- Defined: requester 0 has strict priority. In IDLE, if pending[0], grant 0 regardless of the pointer; the pointer is not advanced by requester-0 grants. Others are round-robin among 1..NUM_REQ-1.
- Undefined: pure round-robin over all requesters as above.

Test Plan:
- Reset mid-ISSUE: write outstanding, assert reset 1 cycle -> all outputs 0, no req_done; the next request is granted from pointer 0.
- Single write: req_write[1]=1, x=10, y=20, wdata=0x5A, others idle -> next cycle mem_write_request=1, mem_x=10, mem_y=20, mem_write_data=0x5A, grant_id=1. One cycle after mem_write_complete, req_done=3'b010 for exactly 1 cycle.
- Single read: req_read[2]=1, x=319, y=239; manager returns 0xC3 -> rdata=0xC3 with req_done[2]=1. rdata is still 0xC3 after a subsequent write completes.
- Round-robin: all three hold writes continuously -> grant order 0,1,2,0,1,2 over 6 transactions; never two mem requests high; each req_done count is 2.
- Simultaneous read+write on requester 0 -> write issued (mem_read_request stays 0); one req_done.
- ARB_PRIORITY0_EN defined: requesters 1 and 2 and requester 0 continuously pending -> every grant goes to 0. With 0 idle, grants alternate 1,2. Undefined: same stimulus gives 0,1,2 rotation.
